// File: rtl/riscv_alu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : riscv_alu_pkg
// Brief    : Shared ALU control codes, mul/div op codes and sequencer states.
// Revision : 1.0 - initial release
// ============================================================================
package riscv_alu_pkg;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b1000;

  typedef enum logic [1:0] {
    MD_MUL   = 2'b00,
    MD_MULHU = 2'b01,
    MD_DIVU  = 2'b10,
    MD_REMU  = 2'b11
  } md_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } md_state_e;

  // Divide ops share bit 1; the "upper" result (hi / rem) is selected by bit 0.
  function automatic logic md_is_div(input md_op_e op);
    return op[1];
  endfunction

  function automatic logic md_takes_acc(input md_op_e op);
    return op[0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/muldiv_seq_if.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_seq_if
// Brief    : Command/result and shared-ALU bundle of the mul/div sequencer.
// Revision : 1.0 - initial release
// ============================================================================
interface muldiv_seq_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] opb;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             alu_req;
  logic             alu_gnt;
  logic [WIDTH-1:0] alu_srca;
  logic [WIDTH-1:0] alu_srcb;
  logic [3:0]       alu_control;
  logic [WIDTH-1:0] alu_out;

  // slave: the sequencer; master: the core (command source and ALU owner)
  modport slave (
    input  start, op, opa, opb, alu_gnt, alu_out,
    output busy, done, result, alu_req, alu_srca, alu_srcb, alu_control
  );

  modport master (
    output start, op, opa, opb, alu_gnt, alu_out,
    input  busy, done, result, alu_req, alu_srca, alu_srcb, alu_control
  );
endinterface
`default_nettype wire

// File: rtl/muldiv_step.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_step
// Brief    : One shift-add / restoring-subtract iteration around the shared ALU.
// Revision : 1.0 - initial release
// ============================================================================
module muldiv_step
  import riscv_alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             is_div,
  input  logic [WIDTH-1:0] acc,      // hi (multiply) or rem (divide)
  input  logic [WIDTH-1:0] q,        // lo (multiply) or quo (divide)
  input  logic [WIDTH-1:0] opa,
  input  logic [WIDTH-1:0] opb,
  input  logic [WIDTH-1:0] alu_out,
  output logic [WIDTH-1:0] srca,
  output logic [WIDTH-1:0] srcb,
  output logic [3:0]       control,
  output logic [WIDTH-1:0] acc_nxt,
  output logic [WIDTH-1:0] q_nxt
);

  logic [WIDTH-1:0] w_mul_b;
  logic [WIDTH-1:0] w_sh;
  logic             w_msb;
  logic             w_carry;
  logic             w_borrow;

  assign w_mul_b = q[0] ? opa : '0;
  assign w_sh    = {acc[WIDTH-2:0], q[WIDTH-1]};
  assign w_msb   = acc[WIDTH-1];

  // The ALU has no carry flag, so carry/borrow are rebuilt from the MSBs.
  assign w_carry  = (acc[WIDTH-1] & w_mul_b[WIDTH-1])
                  | ((acc[WIDTH-1] | w_mul_b[WIDTH-1]) & ~alu_out[WIDTH-1]);
  assign w_borrow = (~w_sh[WIDTH-1] & opb[WIDTH-1])
                  | ((~w_sh[WIDTH-1] | opb[WIDTH-1]) & alu_out[WIDTH-1]);

  always_comb begin
    srca    = acc;
    srcb    = w_mul_b;
    control = ALU_ADD;
    acc_nxt = {w_carry, alu_out[WIDTH-1:1]};
    q_nxt   = {alu_out[0], q[WIDTH-1:1]};
    if (is_div) begin
      srca    = w_sh;
      srcb    = opb;
      control = ALU_SUB;
      // A set msb means the true shifted remainder exceeds 2^WIDTH > divisor.
      if (w_msb | ~w_borrow) begin
        acc_nxt = alu_out;
        q_nxt   = {q[WIDTH-2:0], 1'b1};
      end else begin
        acc_nxt = w_sh;
        q_nxt   = {q[WIDTH-2:0], 1'b0};
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/muldiv_seq.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_seq
// Brief    : Multi-cycle MUL/MULHU/DIVU/REMU sequencer borrowing the core ALU.
// Revision : 1.0 - initial release
// ============================================================================
module muldiv_seq
  import riscv_alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int STEPS = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  muldiv_seq_if.slave bus
);

  localparam int             CNT_W    = $clog2(STEPS);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(STEPS - 1);

  md_state_e        r_state;
  md_op_e           r_op;
  logic [CNT_W-1:0] r_count;
  logic [WIDTH-1:0] r_opa;
  logic [WIDTH-1:0] r_opb;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] r_result;
  logic             r_busy;
  logic             r_done;
  logic             r_alu_req;

  md_op_e           w_op;
  logic [WIDTH-1:0] w_srca;
  logic [WIDTH-1:0] w_srcb;
  logic [3:0]       w_control;
  logic [WIDTH-1:0] w_acc_nxt;
  logic [WIDTH-1:0] w_q_nxt;

  assign w_op = md_op_e'(bus.op);

  muldiv_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .is_div  (md_is_div(r_op)),
    .acc     (r_acc),
    .q       (r_q),
    .opa     (r_opa),
    .opb     (r_opb),
    .alu_out (bus.alu_out),
    .srca    (w_srca),
    .srcb    (w_srcb),
    .control (w_control),
    .acc_nxt (w_acc_nxt),
    .q_nxt   (w_q_nxt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_op      <= MD_MUL;
      r_count   <= '0;
      r_opa     <= '0;
      r_opb     <= '0;
      r_acc     <= '0;
      r_q       <= '0;
      r_result  <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_alu_req <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_done <= 1'b0;
          if (bus.start) begin
            r_op    <= w_op;
            r_opa   <= bus.opa;
            r_opb   <= bus.opb;
            r_count <= '0;
            r_busy  <= 1'b1;
            if (md_is_div(w_op) && (bus.opb == '0)) begin
              // Divide by zero: quotient all ones, remainder is the dividend.
              r_acc    <= bus.opa;
              r_q      <= '1;
              r_result <= md_takes_acc(w_op) ? bus.opa : '1;
              r_done   <= 1'b1;
              r_state  <= DONE;
            end else begin
              r_acc     <= '0;
              r_q       <= md_is_div(w_op) ? bus.opa : bus.opb;
              r_alu_req <= 1'b1;
              r_state   <= RUN;
            end
          end
        end
        RUN: begin
          if (bus.alu_gnt) begin
            r_acc   <= w_acc_nxt;
            r_q     <= w_q_nxt;
            r_count <= r_count + 1'b1;
            if (r_count == LAST_STEP) begin
              // Load the result on entry so it is valid alongside done.
              r_result  <= md_takes_acc(r_op) ? w_acc_nxt : w_q_nxt;
              r_alu_req <= 1'b0;
              r_done    <= 1'b1;
              r_state   <= DONE;
            end
          end
        end
        DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_done    <= 1'b0;
          r_busy    <= 1'b0;
          r_alu_req <= 1'b0;
          r_state   <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy        = r_busy;
  assign bus.done        = r_done;
  assign bus.result      = r_result;
  assign bus.alu_req     = r_alu_req;
  // Operands come straight from held registers, so they stay put while ungranted.
  assign bus.alu_srca    = r_alu_req ? w_srca : '0;
  assign bus.alu_srcb    = r_alu_req ? w_srcb : '0;
  assign bus.alu_control = r_alu_req ? w_control : ALU_ADD;

endmodule
`default_nettype wire
